pll_phase_ctrl: RTL

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

---
 rtl/pll_phase_pkg.sv | 32 +++
 rtl/pll_lock_sync.sv | 25 ++
 rtl/pll_phase_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the PLL dynamic phase-shift controller.
// Holds the FSM state encoding, request-select bit positions and position width.
package pll_phase_pkg;

    localparam int POS_W    = 8;
    localparam int SEL_W    = 3;
    localparam int SEL_OUT0 = 0;
    localparam int SEL_OUT2 = 1;
    localparam int SEL_OUT3 = 2;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_LOAD  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Position arithmetic wraps modulo 256 in both directions.
    function automatic pos_t step_pos(input pos_t pos, input logic advance);
        return advance ? pos + pos_t'(1) : pos - pos_t'(1);
    endfunction

    // States in which the PLL interface is being driven and lock loss aborts.
    function automatic logic is_active(input state_e s);
        return (s == ST_SETUP) || (s == ST_PULSE) || (s == ST_GAP) || (s == ST_LOAD);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock indication into the
// controller clock domain; clears to "unlocked" on reset.
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences PLL dynamic phase-shift requests: select/direction setup, a train of
// rotate pulses, a phase-load strobe, and per-output position tracking.
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_W   = 2,
    parameter int GAP_W     = 2,
    parameter int LOAD_W    = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PLL_LOCK,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [SEL_W-1:0] REQ_SEL,
    input  logic             REQ_DIR,
    input  logic [7:0]       REQ_STEPS,
    output logic             PHASE_OUT0_SEL,
    output logic             PHASE_OUT2_SEL,
    output logic             PHASE_OUT3_SEL,
    output logic             PHASE_DIRECTION,
    output logic             PHASE_ROTATE,
    output logic             LOAD_PHASE_N,
    output logic             DONE,
    output logic             ABORT,
    output logic [POS_W-1:0] POS0,
    output logic [POS_W-1:0] POS2,
    output logic [POS_W-1:0] POS3
);

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t PULSE_LAST = cnt_t'(PULSE_W - 1);
    localparam cnt_t GAP_LAST   = cnt_t'(GAP_W - 1);
    localparam cnt_t LOAD_LAST  = cnt_t'(LOAD_W - 1);

    state_e           state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    pos_t             rem_q, rem_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             dir_q, dir_d;
    pos_t             pos0_q, pos0_d;
    pos_t             pos2_q, pos2_d;
    pos_t             pos3_q, pos3_d;

    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             phase_dir_q, phase_dir_d;
    logic             rotate_q, rotate_d;
    logic             load_n_q, load_n_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    logic             lock_s;
    logic             ready;
    logic             lock_lost;
    logic             active_next;

    pll_lock_sync u_lock_sync (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .async_i (PLL_LOCK),
        .sync_o  (lock_s)
    );

    assign ready     = (state_q == ST_IDLE) && lock_s;
    assign lock_lost = !lock_s && is_active(state_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        pos0_d  = pos0_q;
        pos2_d  = pos2_q;
        pos3_d  = pos3_q;
        abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && ready) begin
                    sel_d = REQ_SEL;
                    dir_d = REQ_DIR;
                    rem_d = REQ_STEPS;
                    cnt_d = '0;
                    // Empty requests complete immediately without touching the PLL.
                    if ((REQ_STEPS != 8'd0) && (REQ_SEL != '0)) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d = '0;
                    rem_d = rem_q - pos_t'(1);
                    if (sel_q[SEL_OUT0]) pos0_d = step_pos(pos0_q, dir_q);
                    if (sel_q[SEL_OUT2]) pos2_d = step_pos(pos2_q, dir_q);
                    if (sel_q[SEL_OUT3]) pos3_d = step_pos(pos3_q, dir_q);
                    state_d = (rem_q != pos_t'(1)) ? ST_GAP : ST_LOAD;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            ST_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Lock loss wins over a pulse completing in the same cycle: that pulse is
        // not counted, since the PLL may not have honoured it.
        if (lock_lost) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rem_d   = '0;
            pos0_d  = pos0_q;
            pos2_d  = pos2_q;
            pos3_d  = pos3_q;
            abort_d = 1'b1;
        end
    end

    // PLL-facing strobes are decoded from the next state and registered so they
    // change only on clock edges and line up exactly with the state they belong to.
    always_comb begin
        active_next = is_active(state_d);
        out_sel_d   = active_next ? sel_d : '0;
        phase_dir_d = active_next && dir_d;
        rotate_d    = (state_d == ST_PULSE);
        load_n_d    = (state_d != ST_LOAD);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            sel_q       <= '0;
            dir_q       <= 1'b0;
            pos0_q      <= '0;
            pos2_q      <= '0;
            pos3_q      <= '0;
            out_sel_q   <= '0;
            phase_dir_q <= 1'b0;
            rotate_q    <= 1'b0;
            load_n_q    <= 1'b1;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            sel_q       <= sel_d;
            dir_q       <= dir_d;
            pos0_q      <= pos0_d;
            pos2_q      <= pos2_d;
            pos3_q      <= pos3_d;
            out_sel_q   <= out_sel_d;
            phase_dir_q <= phase_dir_d;
            rotate_q    <= rotate_d;
            load_n_q    <= load_n_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign REQ_READY       = ready;
    assign PHASE_OUT0_SEL  = out_sel_q[SEL_OUT0];
    assign PHASE_OUT2_SEL  = out_sel_q[SEL_OUT2];
    assign PHASE_OUT3_SEL  = out_sel_q[SEL_OUT3];
    assign PHASE_DIRECTION = phase_dir_q;
    assign PHASE_ROTATE    = rotate_q;
    assign LOAD_PHASE_N    = load_n_q;
    assign DONE            = done_q;
    assign ABORT           = abort_q;
    assign POS0            = pos0_q;
    assign POS2            = pos2_q;
    assign POS3            = pos3_q;

endmodule
